hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Producer-side companion to the forwarding unit. It tracks every destination register that has been issued but not yet written back, using one 2-bit in-flight counter per architectural register. It stalls the ID→IS handoff when an instruction reads a register still pending beyond the forwarding window, or writes a register whose counter is saturated. The block sits beside the ID/IS pipeline register: issue events enter from ID, and clear events come from the writeback stage.

## Interface
Parameters:
- `NREGS`, default 32: number of architectural registers; register 0 is hardwired zero.
- `CNT_W`, default 2: width of each per-register in-flight counter.

Ports:
- `clock_in`, input, 1: core clock; all state updates on the rising edge.
- `reset_n_in`, input, 1: asynchronous, active-low reset.
- `sb_flush_in`, input, 1: pipeline flush; clears all counters next edge.
- `sb_id_valid_in`, input, 1: an instruction in ID requests issue.
- `sb_ra_addr_in`, input, 5: RS1 of the ID instruction.
- `sb_rb_addr_in`, input, 5: RS2 of the ID instruction.
- `sb_ra_used_in`, input, 1: the instruction reads RS1.
- `sb_rb_used_in`, input, 1: the instruction reads RS2.
- `sb_rd_addr_in`, input, 5: RD of the ID instruction.
- `sb_rd_wen_in`, input, 1: the instruction writes RD.
- `sb_wb_valid_in`, input, 1: writeback retires a register write.
- `sb_wb_rd_addr_in`, input, 5: RD being retired.
- `sb_stall_out`, output, 1: hold ID; issue is not accepted this cycle.
- `sb_ra_busy_out`, output, 1: RS1 has a pending write.
- `sb_rb_busy_out`, output, 1: RS2 has a pending write.
- `sb_pending_out`, output, 6: number of registers with a nonzero counter.
- `sb_error_out`, output, 1: sticky flag; set by a writeback to a register whose counter is 0.

## Operation
- State: `cnt[r]` of width `CNT_W` for r = 1..31. `cnt[0]` is constant 0.
- Busy and stall terms (combinational):
  - `ra_busy = ra_used && ra != 0 && cnt[ra] != 0`; `rb_busy` likewise.
  - `rd_full = rd_wen && rd != 0 && cnt[rd] == 2^CNT_W-1`.
  - `sb_stall_out = id_valid && (ra_busy || rb_busy || rd_full)`.
  - `sb_ra_busy_out` and `sb_rb_busy_out` are reported whenever the busy terms hold, regardless of `id_valid`.
- Accept: `issue = id_valid && !sb_stall_out && rd_wen && rd != 0`.
- Counter update per register r, next edge:
  - Increment if `issue` targets r.
  - Decrement if `wb_valid` targets r and `cnt[r] != 0`.
  - Both in the same cycle: counter unchanged.
  - A writeback to a register with `cnt == 0` is ignored and sets `sb_error_out`.
  - A writeback to x0 is ignored with no error.
- Flush: all counters go to 0 next edge. Flush has priority over a same-cycle issue and writeback. `sb_error_out` is not cleared by flush; only reset clears it.
- `sb_pending_out` is a registered population count of nonzero counters, reflecting post-update state.

## Timing
- Reset (async assert, sync-to-clock deassert upstream): all counters 0, `sb_error_out` = 0, `sb_pending_out` = 0. The combinational outputs are therefore 0 during reset.
- `sb_stall_out` and the busy outputs are combinational from registered counters and ID inputs, with zero-cycle latency. They do not depend on writeback inputs unless `SB_WB_BYPASS_EN` is defined.
- Issue takes effect at the next edge: the instruction issued at cycle N makes its RD busy for a consumer in ID at cycle N+1.
- Writeback at cycle N frees the register from cycle N+1 (without bypass).
- Reset mid-operation: state is cleared immediately; no partial updates survive.

## Configuration
- `SB_WB_BYPASS_EN` defined:
  - A same-cycle writeback matching a source register with `cnt == 1` masks that source's busy term, so the consumer issues in cycle N.
  - The same masking applies to `rd_full` when the writeback targets RD.
- Undefined: no same-cycle bypass; the consumer stalls one extra cycle.
- Counter update rules are identical in both builds.

## Test plan
- Reset, then ID = {ra=5 used, rd=5 wen, valid} → `stall` = 0. Next cycle `cnt[5]` = 1, `sb_pending_out` = 1, and ID ra=5 gives `stall` = 1 with `sb_ra_busy_out` = 1.
- Issue rd=7 three times, then a fourth issue with rd=7 → `stall` = 1 (rd_full). One writeback rd=7 → next cycle `stall` = 0 and the fourth issue is accepted; `cnt` stays 3.
- Same cycle: issue rd=9 and writeback rd=9 with `cnt[9]` = 1 → `cnt[9]` remains 1 and `sb_pending_out` is unchanged.
- ra=0 and rd=0 with all counters nonzero → no stall; the x0 issue is not counted; a writeback to x0 does not set `sb_error_out`.
- Writeback rd=12 with `cnt[12]` = 0 → `sb_error_out` = 1 and stays 1 through `sb_flush_in`; clears only on `reset_n_in` = 0.
- Pending rd=3 (`cnt` = 1) with writeback rd=3 in the same cycle as ID reads ra=3 → `stall` = 0 with `SB_WB_BYPASS_EN` defined, 1 without; flush asserted together with an issue → all counters 0 next cycle.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight destination scoreboard gating ID->IS issue
// Optional macro SB_WB_BYPASS_EN: same-cycle writeback masks busy/full terms.
module hazard_scoreboard #(
  parameter int NREGS = 32,
  parameter int CNT_W = 2
) (
  input  logic       clock_in,
  input  logic       reset_n_in,
  input  logic       sb_flush_in,
  input  logic       sb_id_valid_in,
  input  logic [4:0] sb_ra_addr_in,
  input  logic [4:0] sb_rb_addr_in,
  input  logic       sb_ra_used_in,
  input  logic       sb_rb_used_in,
  input  logic [4:0] sb_rd_addr_in,
  input  logic       sb_rd_wen_in,
  input  logic       sb_wb_valid_in,
  input  logic [4:0] sb_wb_rd_addr_in,
  output logic       sb_stall_out,
  output logic       sb_ra_busy_out,
  output logic       sb_rb_busy_out,
  output logic [5:0] sb_pending_out,
  output logic       sb_error_out
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic [CNT_W-1:0] cnt_q [NREGS];
  logic [CNT_W-1:0] cnt_d [NREGS];
  logic             error_q, error_d;
  logic [5:0]       pending_q, pending_d;

  logic [CNT_W-1:0] ra_cnt, rb_cnt, rd_cnt, wb_cnt;
  logic             ra_byp, rb_byp, rd_byp;
  logic             ra_busy, rb_busy, rd_full, issue;

  assign ra_cnt = cnt_q[sb_ra_addr_in];
  assign rb_cnt = cnt_q[sb_rb_addr_in];
  assign rd_cnt = cnt_q[sb_rd_addr_in];
  assign wb_cnt = cnt_q[sb_wb_rd_addr_in];

`ifdef SB_WB_BYPASS_EN
  // Last outstanding write retiring this cycle: the value is on the forwarding path.
  assign ra_byp = sb_wb_valid_in && (sb_wb_rd_addr_in == sb_ra_addr_in) && (ra_cnt == CNT_ONE);
  assign rb_byp = sb_wb_valid_in && (sb_wb_rd_addr_in == sb_rb_addr_in) && (rb_cnt == CNT_ONE);
  assign rd_byp = sb_wb_valid_in && (sb_wb_rd_addr_in == sb_rd_addr_in);
`else
  assign ra_byp = 1'b0;
  assign rb_byp = 1'b0;
  assign rd_byp = 1'b0;
`endif

  assign ra_busy = sb_ra_used_in && (sb_ra_addr_in != 5'd0) && (ra_cnt != CNT_ZERO) && !ra_byp;
  assign rb_busy = sb_rb_used_in && (sb_rb_addr_in != 5'd0) && (rb_cnt != CNT_ZERO) && !rb_byp;
  assign rd_full = sb_rd_wen_in && (sb_rd_addr_in != 5'd0) && (rd_cnt == CNT_MAX) && !rd_byp;

  assign sb_stall_out   = sb_id_valid_in && (ra_busy || rb_busy || rd_full);
  assign sb_ra_busy_out = ra_busy;
  assign sb_rb_busy_out = rb_busy;
  assign issue          = sb_id_valid_in && !sb_stall_out && sb_rd_wen_in && (sb_rd_addr_in != 5'd0);

  always_comb begin
    error_d   = error_q;
    pending_d = '0;
    if (sb_wb_valid_in && (sb_wb_rd_addr_in != 5'd0) && (wb_cnt == CNT_ZERO)) begin
      error_d = 1'b1;
    end
    for (int r = 0; r < NREGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if ((r == 0) || sb_flush_in) begin
        cnt_d[r] = '0;
      end else if (issue && (sb_rd_addr_in == 5'(r))) begin
        if (!(sb_wb_valid_in && (sb_wb_rd_addr_in == 5'(r)) && (cnt_q[r] != CNT_ZERO))) begin
          cnt_d[r] = cnt_q[r] + CNT_ONE;
        end
      end else if (sb_wb_valid_in && (sb_wb_rd_addr_in == 5'(r)) && (cnt_q[r] != CNT_ZERO)) begin
        cnt_d[r] = cnt_q[r] - CNT_ONE;
      end
      pending_d = pending_d + {5'd0, (cnt_d[r] != CNT_ZERO)};
    end
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int r = 0; r < NREGS; r++) begin
        cnt_q[r] <= '0;
      end
      error_q   <= 1'b0;
      pending_q <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      error_q   <= error_d;
      pending_q <= pending_d;
    end
  end

  assign sb_pending_out = pending_q;
  assign sb_error_out   = error_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

  logic       clock_in = 1'b0;
  logic       reset_n_in;
  logic       sb_flush_in;
  logic       sb_id_valid_in;
  logic [4:0] sb_ra_addr_in;
  logic [4:0] sb_rb_addr_in;
  logic       sb_ra_used_in;
  logic       sb_rb_used_in;
  logic [4:0] sb_rd_addr_in;
  logic       sb_rd_wen_in;
  logic       sb_wb_valid_in;
  logic [4:0] sb_wb_rd_addr_in;
  logic       sb_stall_out;
  logic       sb_ra_busy_out;
  logic       sb_rb_busy_out;
  logic [5:0] sb_pending_out;
  logic       sb_error_out;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_scoreboard dut (
    .clock_in        (clock_in),
    .reset_n_in      (reset_n_in),
    .sb_flush_in     (sb_flush_in),
    .sb_id_valid_in  (sb_id_valid_in),
    .sb_ra_addr_in   (sb_ra_addr_in),
    .sb_rb_addr_in   (sb_rb_addr_in),
    .sb_ra_used_in   (sb_ra_used_in),
    .sb_rb_used_in   (sb_rb_used_in),
    .sb_rd_addr_in   (sb_rd_addr_in),
    .sb_rd_wen_in    (sb_rd_wen_in),
    .sb_wb_valid_in  (sb_wb_valid_in),
    .sb_wb_rd_addr_in(sb_wb_rd_addr_in),
    .sb_stall_out    (sb_stall_out),
    .sb_ra_busy_out  (sb_ra_busy_out),
    .sb_rb_busy_out  (sb_rb_busy_out),
    .sb_pending_out  (sb_pending_out),
    .sb_error_out    (sb_error_out)
  );

  always #5 clock_in = ~clock_in;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] ra, input logic rau,
                        input logic [4:0] rb, input logic rbu,
                        input logic [4:0] rd, input logic wen);
    sb_id_valid_in = v;
    sb_ra_addr_in  = ra;
    sb_ra_used_in  = rau;
    sb_rb_addr_in  = rb;
    sb_rb_used_in  = rbu;
    sb_rd_addr_in  = rd;
    sb_rd_wen_in   = wen;
  endtask

  task automatic set_wb(input logic v, input logic [4:0] a);
    sb_wb_valid_in   = v;
    sb_wb_rd_addr_in = a;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    set_wb(1'b0, 5'd0);
    sb_flush_in = 1'b0;
  endtask

  // Inputs change 1 time unit after the rising edge; checks run one unit later.
  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  initial begin
    reset_n_in = 1'b0;
    idle();
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);
    #1;
    check_eq("rst_stall", {31'd0, sb_stall_out}, 0);
    check_eq("rst_pending", {26'd0, sb_pending_out}, 0);
    check_eq("rst_error", {31'd0, sb_error_out}, 0);
    tick();
    tick();
    reset_n_in = 1'b1;
    idle();

    // Producer then consumer of r5
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);
    #1 check_eq("t1_first_stall", {31'd0, sb_stall_out}, 0);
    tick();
    check_eq("t1_pending", {26'd0, sb_pending_out}, 1);
    check_eq("t1_second_stall", {31'd0, sb_stall_out}, 1);
    check_eq("t1_ra_busy", {31'd0, sb_ra_busy_out}, 1);
    tick();
    check_eq("t1_stalled_no_issue", {26'd0, sb_pending_out}, 1);
    set_id(1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
    #1;
    check_eq("t1_busy_no_valid_stall", {31'd0, sb_stall_out}, 0);
    check_eq("t1_busy_no_valid_ra", {31'd0, sb_ra_busy_out}, 1);
    check_eq("t1_busy_no_valid_rb", {31'd0, sb_rb_busy_out}, 1);
    idle();
    set_wb(1'b1, 5'd5);
    tick();
    idle();
    check_eq("t1_drained", {26'd0, sb_pending_out}, 0);

    // Saturate r7
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    check_eq("t2_pending", {26'd0, sb_pending_out}, 1);
    check_eq("t2_full_stall", {31'd0, sb_stall_out}, 1);
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    set_wb(1'b1, 5'd7);
    tick();
    set_wb(1'b0, 5'd0);
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    #1 check_eq("t2_after_wb_stall", {31'd0, sb_stall_out}, 0);
    tick();
    check_eq("t2_refull_stall", {31'd0, sb_stall_out}, 1);
    idle();
    set_wb(1'b1, 5'd7);
    for (int i = 0; i < 3; i++) tick();
    idle();
    check_eq("t2_drained", {26'd0, sb_pending_out}, 0);
    check_eq("t2_no_error", {31'd0, sb_error_out}, 0);

    // Issue and writeback of r9 in the same cycle
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
    tick();
    set_wb(1'b1, 5'd9);
    #1 check_eq("t3_same_cycle_stall", {31'd0, sb_stall_out}, 0);
    tick();
    idle();
    check_eq("t3_pending", {26'd0, sb_pending_out}, 1);
    set_id(1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1 check_eq("t3_r9_busy", {31'd0, sb_ra_busy_out}, 1);
    idle();
    set_wb(1'b1, 5'd9);
    tick();
    idle();
    check_eq("t3_drained", {26'd0, sb_pending_out}, 0);

    // All registers pending, x0 traffic
    for (int r = 1; r < 32; r++) begin
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'(r), 1'b1);
      tick();
    end
    check_eq("t4_all_pending", {26'd0, sb_pending_out}, 31);
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
    #1;
    check_eq("t4_x0_stall", {31'd0, sb_stall_out}, 0);
    check_eq("t4_x0_ra_busy", {31'd0, sb_ra_busy_out}, 0);
    tick();
    check_eq("t4_x0_not_counted", {26'd0, sb_pending_out}, 31);
    set_id(1'b1, 5'd17, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0);
    #1 check_eq("t4_r17_stall", {31'd0, sb_stall_out}, 1);
    idle();
    set_wb(1'b1, 5'd0);
    tick();
    idle();
    check_eq("t4_wb_x0_error", {31'd0, sb_error_out}, 0);
    check_eq("t4_wb_x0_pending", {26'd0, sb_pending_out}, 31);
    sb_flush_in = 1'b1;
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
    tick();
    idle();
    check_eq("t4_flush_pending", {26'd0, sb_pending_out}, 0);
    set_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1 check_eq("t4_flush_r4_stall", {31'd0, sb_stall_out}, 0);
    idle();

    // Writeback to an idle register is sticky-flagged
    set_wb(1'b1, 5'd12);
    tick();
    idle();
    check_eq("t5_error_set", {31'd0, sb_error_out}, 1);
    check_eq("t5_error_pending", {26'd0, sb_pending_out}, 0);
    sb_flush_in = 1'b1;
    tick();
    idle();
    check_eq("t5_error_through_flush", {31'd0, sb_error_out}, 1);

    // Consumer meets the retiring write of r3
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
    tick();
    set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    set_wb(1'b1, 5'd3);
    #1;
`ifdef SB_WB_BYPASS_EN
    check_eq("t6_bypass_stall", {31'd0, sb_stall_out}, 0);
`else
    check_eq("t6_bypass_stall", {31'd0, sb_stall_out}, 1);
`endif
    tick();
    idle();
    check_eq("t6_pending", {26'd0, sb_pending_out}, 0);
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
    tick();
    tick();
    check_eq("t6_two_pending", {26'd0, sb_pending_out}, 1);
    set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    set_wb(1'b1, 5'd3);
    #1 check_eq("t6_cnt2_stall", {31'd0, sb_stall_out}, 1);
    tick();
    idle();
    check_eq("t6_cnt2_after_wb", {26'd0, sb_pending_out}, 1);
    sb_flush_in = 1'b1;
    tick();
    idle();

    // Asynchronous reset mid-operation
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1);
    tick();
    check_eq("t7_pre_pending", {26'd0, sb_pending_out}, 1);
    #2 reset_n_in = 1'b0;
    set_id(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    check_eq("t7_rst_pending", {26'd0, sb_pending_out}, 0);
    check_eq("t7_rst_error", {31'd0, sb_error_out}, 0);
    check_eq("t7_rst_stall", {31'd0, sb_stall_out}, 0);
    #1 reset_n_in = 1'b1;
    idle();
    tick();
    check_eq("t7_post_pending", {26'd0, sb_pending_out}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
